// File: rtl/pdn_rail_sequencer.sv
// Power-rail sequencer: brings rails up in ascending order gated on power-good,
// takes them down in descending order, and latches the offending rail on a fault.
module pdn_rail_sequencer #(
    parameter int N_RAILS     = 6,
    parameter int TIMEOUT_CYC = 8,
    parameter int SETTLE_CYC  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pwr_req,
    input  logic [N_RAILS-1:0] pg,
    input  logic               fault_clr,
    output logic [N_RAILS-1:0] rail_en,
    output logic               all_on,
    output logic               all_off,
    output logic               fault,
    output logic [2:0]         fault_rail,
    output logic [2:0]         state
);

    localparam int MAX_CYC = (TIMEOUT_CYC > SETTLE_CYC) ? TIMEOUT_CYC : SETTLE_CYC;
    localparam int CW      = $clog2(MAX_CYC + 1);
    localparam logic [2:0]    LAST_IDX = 3'(N_RAILS - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYC - 1);
    localparam logic [CW-1:0] ST_LAST  = CW'(SETTLE_CYC - 1);

    typedef enum logic [2:0] {
        S_OFF       = 3'd0,
        S_UP_WAIT   = 3'd1,
        S_UP_SETTLE = 3'd2,
        S_ON        = 3'd3,
        S_DN_SETTLE = 3'd4,
        S_FAULT     = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         idx_q, idx_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [N_RAILS-1:0] rail_en_q, rail_en_d;
    logic [2:0]         fault_rail_q, fault_rail_d;

    logic [N_RAILS-1:0] chk;
    logic               drop_hit;
    logic [2:0]         drop_idx;
    logic               flt_go;
    logic [2:0]         flt_idx;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_OFF;
            idx_q        <= '0;
            cnt_q        <= '0;
            rail_en_q    <= '0;
            fault_rail_q <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            rail_en_q    <= rail_en_d;
            fault_rail_q <= fault_rail_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        rail_en_d    = rail_en_q;
        fault_rail_d = fault_rail_q;
        flt_go       = 1'b0;
        drop_hit     = 1'b0;
        drop_idx     = '0;

        // Rails past their wait phase are the enabled ones, minus the one still waiting for pg.
        chk = rail_en_q;
        if (state_q == S_UP_WAIT) chk[idx_q] = 1'b0;
        for (int i = N_RAILS - 1; i >= 0; i--) begin
            if (chk[i] && !pg[i]) begin
                drop_hit = 1'b1;
                drop_idx = 3'(i);
            end
        end
        flt_idx = drop_idx;

        case (state_q)
            S_OFF: begin
                if (pwr_req) begin
                    idx_d        = '0;
                    rail_en_d    = '0;
                    rail_en_d[0] = 1'b1;
                    cnt_d        = '0;
                    state_d      = S_UP_WAIT;
                end
            end
            S_UP_WAIT: begin
                if (drop_hit) begin
                    flt_go = 1'b1;
                end else if (!pg[idx_q] && cnt_q == TO_LAST) begin
                    flt_go  = 1'b1;
                    flt_idx = idx_q;
                end else if (!pwr_req) begin
                    rail_en_d[idx_q] = 1'b0;
                    cnt_d            = '0;
                    state_d          = S_DN_SETTLE;
                end else if (pg[idx_q]) begin
                    cnt_d   = '0;
                    state_d = S_UP_SETTLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_UP_SETTLE: begin
                if (drop_hit) begin
                    flt_go = 1'b1;
                end else if (!pwr_req) begin
                    rail_en_d[idx_q] = 1'b0;
                    cnt_d            = '0;
                    state_d          = S_DN_SETTLE;
                end else if (cnt_q == ST_LAST) begin
                    cnt_d = '0;
                    if (idx_q == LAST_IDX) begin
                        state_d = S_ON;
                    end else begin
                        idx_d                     = idx_q + 3'd1;
                        rail_en_d[idx_q + 3'd1]   = 1'b1;
                        state_d                   = S_UP_WAIT;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_ON: begin
                if (drop_hit) begin
                    flt_go = 1'b1;
                end else if (!pwr_req) begin
                    rail_en_d[LAST_IDX] = 1'b0;
                    idx_d               = LAST_IDX;
                    cnt_d               = '0;
                    state_d             = S_DN_SETTLE;
                end
            end
            S_DN_SETTLE: begin
                // Power-down runs to completion regardless of pg or a renewed request.
                if (cnt_q == ST_LAST) begin
                    cnt_d = '0;
                    if (idx_q == '0) begin
                        state_d = S_OFF;
                    end else begin
                        idx_d                   = idx_q - 3'd1;
                        rail_en_d[idx_q - 3'd1] = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_FAULT: begin
                if (fault_clr && !pwr_req) begin
                    idx_d   = '0;
                    cnt_d   = '0;
                    state_d = S_OFF;
                end
            end
            default: state_d = S_OFF;
        endcase

        if (flt_go) begin
            state_d      = S_FAULT;
            rail_en_d    = '0;
            cnt_d        = '0;
            fault_rail_d = flt_idx;
        end
    end

    assign rail_en    = rail_en_q;
    assign all_on     = (state_q == S_ON);
    assign all_off    = (state_q == S_OFF);
    assign fault      = (state_q == S_FAULT);
    assign fault_rail = fault_rail_q;
    assign state      = state_q;

endmodule
